// File: rtl/epochtv1_vidcap.sv
// Frame grabber for the Epoch TV-1 video stream: on ARM it aligns to the next
// frame boundary and writes every active pixel of one frame through a small FIFO.
module epochtv1_vidcap #(
  parameter int unsigned FIFO_DEPTH = 8,
  parameter int unsigned ADDR_W     = 16
) (
  input  logic              CLK,
  input  logic              RESB,
  input  logic              CE,
  input  logic              DE,
  input  logic              HS,
  input  logic              VS,
  input  logic [23:0]       RGB,
  input  logic              ARM,
  output logic              BUSY,
  output logic              DONE,
  output logic              OVF,
  output logic [8:0]        LINES,
  output logic [ADDR_W-1:0] MEM_A,
  output logic [23:0]       MEM_D,
  output logic              MEM_REQ,
  input  logic              MEM_ACK
);

  localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam int unsigned PIX_W = 24;
  localparam int unsigned ENT_W = ADDR_W + PIX_W;
  localparam int unsigned LIN_W = 9;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_VS,
    S_SYNC,
    S_CAPTURE,
    S_DRAIN
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] pa_q, pa_d;
  logic [LIN_W-1:0]  lines_q, lines_d;
  logic              ovf_q, ovf_d;
  logic              de_prev_q, de_prev_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              req_q, req_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ENT_W-1:0]  head_q, head_d;
  logic [ENT_W-1:0]  fifo_mem [FIFO_DEPTH];

  logic              capture;
  logic              push;
  logic              pop;
  logic              full;
  logic [ENT_W-1:0]  wr_data;

  // Line boundaries come from DE falling edges, so HS carries no extra information.
  logic unused_hs;
  assign unused_hs = HS;

  assign pop     = req_q & MEM_ACK;
  assign full    = (cnt_q == CNT_W'(FIFO_DEPTH));
  assign wr_data = {pa_q, RGB};

  // Capture FSM, pixel address, line counter and error flag.
  always_comb begin
    state_d   = state_q;
    pa_d      = pa_q;
    lines_d   = lines_q;
    ovf_d     = ovf_q;
    de_prev_d = de_prev_q;
    done_d    = 1'b0;
    capture   = 1'b0;
    push      = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (ARM) begin
          state_d   = S_WAIT_VS;
          pa_d      = '0;
          lines_d   = '0;
          ovf_d     = 1'b0;
          de_prev_d = 1'b0;
        end
      end
      S_WAIT_VS: begin
        if (CE && VS) state_d = S_SYNC;
      end
      S_SYNC: begin
        if (CE && !VS) begin
          state_d = S_CAPTURE;
          capture = 1'b1;
        end
      end
      S_CAPTURE: begin
        if (CE) begin
          if (VS) state_d = S_DRAIN;
          else    capture = 1'b1;
        end
      end
      S_DRAIN: begin
        // Request is only ever outstanding while the FIFO holds entries.
        if (cnt_q == '0) begin
          done_d  = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (capture) begin
      de_prev_d = DE;
      if (DE) begin
        pa_d = pa_q + ADDR_W'(1);
        if (pa_q == '1) ovf_d = 1'b1;
        if (full && !pop) ovf_d = 1'b1;
        else              push  = 1'b1;
      end
      if (de_prev_q && !DE && (lines_q != '1)) lines_d = lines_q + LIN_W'(1);
    end
  end

  // FIFO pointers and the registered head presented on the memory port.
  always_comb begin
    rd_ptr_d = rd_ptr_q + PTR_W'(pop);
    wr_ptr_d = wr_ptr_q + PTR_W'(push);
    cnt_d    = cnt_q + CNT_W'(push) - CNT_W'(pop);
    req_d    = (cnt_d != '0);
    busy_d   = (state_d != S_IDLE);
    head_d   = head_q;
    if (cnt_d != '0) begin
      if (push && (wr_ptr_q == rd_ptr_d)) head_d = wr_data;
      else                                head_d = fifo_mem[rd_ptr_d];
    end
  end

  always_ff @(posedge CLK or negedge RESB) begin
    if (!RESB) begin
      state_q   <= S_IDLE;
      pa_q      <= '0;
      lines_q   <= '0;
      ovf_q     <= 1'b0;
      de_prev_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      req_q     <= 1'b0;
      rd_ptr_q  <= '0;
      wr_ptr_q  <= '0;
      cnt_q     <= '0;
      head_q    <= '0;
    end else begin
      state_q   <= state_d;
      pa_q      <= pa_d;
      lines_q   <= lines_d;
      ovf_q     <= ovf_d;
      de_prev_q <= de_prev_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      req_q     <= req_d;
      rd_ptr_q  <= rd_ptr_d;
      wr_ptr_q  <= wr_ptr_d;
      cnt_q     <= cnt_d;
      head_q    <= head_d;
    end
  end

  // FIFO storage needs no reset; validity is tracked by cnt_q.
  always_ff @(posedge CLK) begin
    if (push) fifo_mem[wr_ptr_q] <= wr_data;
  end

  assign BUSY    = busy_q;
  assign DONE    = done_q;
  assign OVF     = ovf_q;
  assign LINES   = lines_q;
  assign MEM_A   = head_q[ENT_W-1 -: ADDR_W];
  assign MEM_D   = head_q[PIX_W-1:0];
  assign MEM_REQ = req_q;

endmodule

// File: tb/tb_epochtv1_vidcap.sv
// Self-checking bench for epochtv1_vidcap: synthetic video frames, a memory-side
// monitor, and a pixel-list reference model of the expected writes.
module tb_epochtv1_vidcap;

  localparam int unsigned FD       = 4;
  localparam int unsigned AW       = 5;
  localparam int unsigned PIX_CLKS = 7;

  logic          CLK = 1'b0;
  logic          RESB, CE, DE, HS, VS, ARM, MEM_ACK;
  logic [23:0]   RGB;
  logic          BUSY, DONE, OVF, MEM_REQ;
  logic [8:0]    LINES;
  logic [AW-1:0] MEM_A;
  logic [23:0]   MEM_D;

  epochtv1_vidcap #(.FIFO_DEPTH(FD), .ADDR_W(AW)) dut (
    .CLK(CLK), .RESB(RESB), .CE(CE), .DE(DE), .HS(HS), .VS(VS), .RGB(RGB),
    .ARM(ARM), .BUSY(BUSY), .DONE(DONE), .OVF(OVF), .LINES(LINES),
    .MEM_A(MEM_A), .MEM_D(MEM_D), .MEM_REQ(MEM_REQ), .MEM_ACK(MEM_ACK)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [AW-1:0] a;
    logic [23:0]   d;
  } wr_t;

  typedef struct {
    int nl; int np; int mode; int ack; int rel;
    int lo; int hi; int lines; int ovf;
  } vec_t;

  int          checks = 0;
  int          errors = 0;
  int          done_cnt = 0;
  int          ack_mode = 0;       // 0 held low, 1 tied high, 2 random
  int          release_after = -1; // active pixel count at which ACK is tied high
  int          active_sent = 0;
  int          zeros = 0;
  wr_t         got_q[$];
  logic [23:0] px_q[$];
  vec_t        tbl[6];

  logic          prev_stall = 1'b0;
  logic [AW-1:0] prev_a = '0;
  logic [23:0]   prev_d = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Memory-side monitor: sampled between edges, sees what the next edge will use.
  always @(negedge CLK) begin
    #1;
    if (RESB) begin
      if (prev_stall) begin
        chk("hold_req", 32'(MEM_REQ), 32'd1);
        chk("hold_a", 32'(MEM_A), 32'(prev_a));
        chk("hold_d", 32'(MEM_D), 32'(prev_d));
      end
      if (MEM_REQ && MEM_ACK) got_q.push_back('{a: MEM_A, d: MEM_D});
      if (DONE) done_cnt++;
      prev_stall = MEM_REQ && !MEM_ACK;
      prev_a     = MEM_A;
      prev_d     = MEM_D;
    end else begin
      prev_stall = 1'b0;
    end
  end

  // Memory acknowledge driver; random mode never stalls more than 10 cycles.
  initial begin
    MEM_ACK = 1'b0;
    forever begin
      @(negedge CLK);
      if (ack_mode == 0)      MEM_ACK = 1'b0;
      else if (ack_mode == 1) MEM_ACK = 1'b1;
      else begin
        MEM_ACK = ($urandom_range(0, 99) < 30) || (zeros >= 10);
        zeros   = MEM_ACK ? 0 : zeros + 1;
      end
    end
  end

  task automatic pix(input logic de, input logic hs, input logic vs, input logic [23:0] c);
    @(negedge CLK);
    CE = 1'b1; DE = de; HS = hs; VS = vs; RGB = c;
    @(negedge CLK);
    CE = 1'b0;
    if (de) begin
      active_sent++;
      if (active_sent == release_after) ack_mode = 1;
    end
    repeat (PIX_CLKS - 2) @(negedge CLK);
  endtask

  task automatic pulse_arm();
    @(negedge CLK); ARM = 1'b1;
    @(negedge CLK); ARM = 1'b0;
  endtask

  task automatic send_vs();
    repeat (3) pix(1'b0, 1'b0, 1'b1, 24'h0);
    repeat (2) pix(1'b0, 1'b0, 1'b0, 24'h0);
  endtask

  task automatic send_lines(input int nl, input int np, input int mode, input bit rec,
                            input int rearm_line);
    logic [23:0] c;
    for (int l = 0; l < nl; l++) begin
      if (l == rearm_line) pulse_arm();
      pix(1'b0, 1'b1, 1'b0, 24'h0);
      pix(1'b0, 1'b0, 1'b0, 24'h0);
      for (int x = 0; x < np; x++) begin
        c = (mode == 0) ? 24'(l * 16 + x) : 24'($urandom);
        if (rec) px_q.push_back(c);
        pix(1'b1, 1'b0, 1'b0, c);
      end
    end
    repeat (2) pix(1'b0, 1'b0, 1'b0, 24'h0);
  endtask

  task automatic wait_done(input string tag, input int budget);
    int n = 0;
    while (done_cnt == 0 && n < budget) begin
      @(negedge CLK);
      n++;
    end
    chk({tag, "_done_seen"}, 32'(done_cnt > 0), 32'd1);
  endtask

  // Reference: pixel k of the frame lands at address k mod 2^AW unless dropped.
  task automatic compare_writes(input string tag, input int lo, input int hi);
    wr_t e[$];
    for (int k = 0; k < px_q.size(); k++)
      if (k < lo || k > hi) e.push_back('{a: AW'(k), d: px_q[k]});
    chk({tag, "_nwrites"}, 32'(got_q.size()), 32'(e.size()));
    for (int k = 0; k < e.size() && k < got_q.size(); k++) begin
      chk($sformatf("%s_addr%0d", tag, k), 32'(got_q[k].a), 32'(e[k].a));
      chk($sformatf("%s_data%0d", tag, k), 32'(got_q[k].d), 32'(e[k].d));
    end
  endtask

  task automatic clear_run();
    got_q.delete();
    px_q.delete();
    done_cnt    = 0;
    active_sent = 0;
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    string tag;
    tag = $sformatf("v%0d", idx);
    clear_run();
    ack_mode      = v.ack;
    release_after = v.rel;
    pulse_arm();
    #1;
    chk({tag, "_busy_arm"}, 32'(BUSY), 32'd1);
    send_vs();
    send_lines(v.nl, v.np, v.mode, 1'b1, -1);
    send_vs();
    wait_done(tag, 3000);
    repeat (5) @(negedge CLK);
    #1;
    compare_writes(tag, v.lo, v.hi);
    chk({tag, "_lines"}, 32'(LINES), 32'(v.lines));
    chk({tag, "_ovf"}, 32'(OVF), 32'(v.ovf));
    chk({tag, "_done_pulses"}, 32'(done_cnt), 32'd1);
    chk({tag, "_busy_end"}, 32'(BUSY), 32'd0);
    chk({tag, "_req_end"}, 32'(MEM_REQ), 32'd0);
  endtask

  initial begin
    tbl[0] = '{nl: 4, np: 6,  mode: 0, ack: 1, rel: -1, lo: 9999, hi: 9999, lines: 4, ovf: 0};
    tbl[1] = '{nl: 3, np: 5,  mode: 1, ack: 2, rel: -1, lo: 9999, hi: 9999, lines: 3, ovf: 0};
    tbl[2] = '{nl: 2, np: 8,  mode: 1, ack: 2, rel: -1, lo: 9999, hi: 9999, lines: 2, ovf: 0};
    tbl[3] = '{nl: 1, np: 12, mode: 1, ack: 0, rel: 8,  lo: 4,    hi: 7,    lines: 1, ovf: 1};
    tbl[4] = '{nl: 4, np: 10, mode: 1, ack: 1, rel: -1, lo: 9999, hi: 9999, lines: 4, ovf: 1};
    tbl[5] = '{nl: 6, np: 3,  mode: 1, ack: 2, rel: -1, lo: 9999, hi: 9999, lines: 6, ovf: 0};

    RESB = 1'b1; CE = 1'b0; DE = 1'b0; HS = 1'b0; VS = 1'b0; RGB = 24'h0; ARM = 1'b0;
    #2 RESB = 1'b0;
    repeat (3) @(negedge CLK);
    #1;
    chk("rst_busy", 32'(BUSY), 32'd0);
    chk("rst_done", 32'(DONE), 32'd0);
    chk("rst_ovf", 32'(OVF), 32'd0);
    chk("rst_lines", 32'(LINES), 32'd0);
    chk("rst_req", 32'(MEM_REQ), 32'd0);
    chk("rst_a", 32'(MEM_A), 32'd0);
    chk("rst_d", 32'(MEM_D), 32'd0);
    @(negedge CLK);
    RESB = 1'b1;
    repeat (3) @(negedge CLK);

    for (int i = 0; i < 6; i++) run_vec(i, tbl[i]);

    // Arm mid-frame: nothing captured until VS rises and falls; re-arm while busy ignored.
    clear_run();
    ack_mode = 1; release_after = -1;
    pulse_arm();
    send_lines(2, 5, 1, 1'b0, -1);
    #1;
    chk("align_no_writes", 32'(got_q.size()), 32'd0);
    chk("align_busy", 32'(BUSY), 32'd1);
    send_vs();
    send_lines(3, 4, 1, 1'b1, 1);
    send_vs();
    wait_done("align", 3000);
    repeat (10) @(negedge CLK);
    #1;
    compare_writes("align", 9999, 9999);
    chk("align_lines", 32'(LINES), 32'd3);
    chk("align_done_pulses", 32'(done_cnt), 32'd1);
    chk("align_busy_end", 32'(BUSY), 32'd0);

    // Reset mid-capture with three entries queued behind a stalled memory.
    clear_run();
    ack_mode = 0;
    pulse_arm();
    send_vs();
    pix(1'b0, 1'b1, 1'b0, 24'h0);
    pix(1'b1, 1'b0, 1'b0, 24'hA5A5A5);
    pix(1'b1, 1'b0, 1'b0, 24'h5A5A5A);
    pix(1'b0, 1'b1, 1'b0, 24'h0);
    pix(1'b1, 1'b0, 1'b0, 24'h123456);
    #1;
    chk("pre_rst_req", 32'(MEM_REQ), 32'd1);
    chk("pre_rst_lines", 32'(LINES), 32'd1);
    chk("pre_rst_d", 32'(MEM_D), 32'hA5A5A5);
    @(negedge CLK);
    RESB = 1'b0;
    #1;
    chk("mid_rst_busy", 32'(BUSY), 32'd0);
    chk("mid_rst_done", 32'(DONE), 32'd0);
    chk("mid_rst_ovf", 32'(OVF), 32'd0);
    chk("mid_rst_lines", 32'(LINES), 32'd0);
    chk("mid_rst_req", 32'(MEM_REQ), 32'd0);
    chk("mid_rst_a", 32'(MEM_A), 32'd0);
    chk("mid_rst_d", 32'(MEM_D), 32'd0);
    repeat (2) @(negedge CLK);
    RESB = 1'b1;
    ack_mode = 1;
    repeat (10) @(negedge CLK);
    #1;
    chk("post_rst_req", 32'(MEM_REQ), 32'd0);
    chk("post_rst_busy", 32'(BUSY), 32'd0);
    chk("post_rst_writes", 32'(got_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
